mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (LW/SW) of the 5-stage MIPS pipeline. It sequences one outstanding RAM transaction at a time, with memory-stage priority and a fetch starvation guard. It generates the per-requester stall signals the pipeline uses while an access is pending.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified RAM port between the fetch stage and the
//               memory stage. One outstanding transaction at a time, memory
//               stage wins contests, fetch starvation guard, stall outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // fetch stage
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  fetch_stall,
  // memory stage
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,
  output logic                  mem_stall,
  // RAM side
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_WAIT = 2'd1,
    DATA_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  state_t                state_q;
  logic                  ram_req_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [DATA_WIDTH-1:0] fetch_data_q;
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  fetch_valid_q;
  logic                  mem_done_q;
  logic [3:0]            starve_cnt_q;
  logic [3:0]            starve_cnt_d;

  logic fetch_elig_d;
  logic mem_elig_d;
  logic fetch_wins_d;
  logic grant_fetch_d;
  logic grant_data_d;

  // Arbitration: a requester whose completion pulse is high this cycle is
  // still dropping its request, so it must not be granted again at this edge.
  always_comb begin
    fetch_elig_d  = fetch_req & ~fetch_valid_q;
    mem_elig_d    = mem_req & ~mem_done_q;
    fetch_wins_d  = fetch_elig_d & (~mem_elig_d | (starve_cnt_q == C_STARVE_LIMIT));
    grant_fetch_d = (state_q == IDLE) & fetch_wins_d;
    grant_data_d  = (state_q == IDLE) & mem_elig_d & ~fetch_wins_d;
    starve_cnt_d  = starve_cnt_q;
    if (grant_fetch_d) begin
      starve_cnt_d = 4'd0;
    end else if (grant_data_d && fetch_req && (starve_cnt_q < C_STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Transaction sequencer with registered RAM controls and completion pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      fetch_data_q  <= '0;
      mem_rdata_q   <= '0;
      fetch_valid_q <= 1'b0;
      mem_done_q    <= 1'b0;
      starve_cnt_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          fetch_valid_q <= 1'b0;
          mem_done_q    <= 1'b0;
          starve_cnt_q  <= starve_cnt_d;
          if (grant_data_d) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= mem_we;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
            state_q     <= DATA_WAIT;
          end else if (grant_fetch_d) begin
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= fetch_addr;
            state_q    <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (ram_ack) begin
            ram_req_q     <= 1'b0;
            ram_we_q      <= 1'b0;
            fetch_data_q  <= ram_rdata;
            fetch_valid_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        DATA_WAIT: begin
          if (ram_ack) begin
            ram_req_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            // stores leave the previous load result in place
            if (!ram_we_q) begin
              mem_rdata_q <= ram_rdata;
            end
            mem_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          ram_req_q <= 1'b0;
          ram_we_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ram_req     = ram_req_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_done    = mem_done_q;
  assign fetch_stall = fetch_req & ~fetch_valid_q;
  assign mem_stall   = mem_req & ~mem_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .fetch_stall(fetch_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .mem_stall  (mem_stall),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    ram_rdata  = 32'h0;
    ram_ack    = 1'b0;
    #2;
    chk("rst_ram_req",     {31'd0, ram_req},     32'd0);
    chk("rst_ram_we",      {31'd0, ram_we},      32'd0);
    chk("rst_ram_addr",    ram_addr,             32'd0);
    chk("rst_ram_wdata",   ram_wdata,            32'd0);
    chk("rst_fetch_data",  fetch_data,           32'd0);
    chk("rst_mem_rdata",   mem_rdata,            32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mem_done",    {31'd0, mem_done},    32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // ---------------- single fetch, ack two cycles after issue ----------------
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0040;
    #1;
    chk("f_stall_pre",  {31'd0, fetch_stall}, 32'd1);
    chk("f_ramreq_pre", {31'd0, ram_req},     32'd0);
    tick();
    chk("f_ramreq",   {31'd0, ram_req},     32'd1);
    chk("f_ramaddr",  ram_addr,             32'h40);
    chk("f_ramwe",    {31'd0, ram_we},      32'd0);
    chk("f_stall1",   {31'd0, fetch_stall}, 32'd1);
    tick();
    chk("f_ramaddr2", ram_addr,             32'h40);
    chk("f_ramwe2",   {31'd0, ram_we},      32'd0);
    chk("f_valid0",   {31'd0, fetch_valid}, 32'd0);
    chk("f_stall2",   {31'd0, fetch_stall}, 32'd1);
    ram_ack   = 1'b1;
    ram_rdata = 32'h2408_0005;
    tick();
    ram_ack   = 1'b0;
    chk("f_valid",    {31'd0, fetch_valid}, 32'd1);
    chk("f_data",     fetch_data,           32'h2408_0005);
    chk("f_stall_pl", {31'd0, fetch_stall}, 32'd0);
    chk("f_ramreq_d", {31'd0, ram_req},     32'd0);
    fetch_req = 1'b0;
    tick();
    chk("f_valid_end", {31'd0, fetch_valid}, 32'd0);
    chk("f_noreissue", {31'd0, ram_req},     32'd0);

    // ---------------- store with immediate ack ----------------
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0100;
    mem_wdata = 32'hDEAD_BEEF;
    tick();
    chk("s_ramreq",   {31'd0, ram_req},   32'd1);
    chk("s_ramwe",    {31'd0, ram_we},    32'd1);
    chk("s_ramaddr",  ram_addr,           32'h100);
    chk("s_ramwdata", ram_wdata,          32'hDEAD_BEEF);
    chk("s_stall",    {31'd0, mem_stall}, 32'd1);
    ram_ack   = 1'b1;
    ram_rdata = 32'h5555_AAAA;
    tick();
    ram_ack   = 1'b0;
    chk("s_done",     {31'd0, mem_done},  32'd1);
    chk("s_rdata",    mem_rdata,          32'd0);
    chk("s_stall_pl", {31'd0, mem_stall}, 32'd0);
    chk("s_ramwe_d",  {31'd0, ram_we},    32'd0);
    mem_req = 1'b0;
    mem_we  = 1'b0;
    tick();
    chk("s_done_end", {31'd0, mem_done}, 32'd0);
    chk("s_noreissue", {31'd0, ram_req}, 32'd0);

    // ---------------- contest: data first, then fetch ----------------
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0044;
    mem_req    = 1'b1;
    mem_we     = 1'b0;
    mem_addr   = 32'h0000_0200;
    tick();
    chk("c_ramaddr_d", ram_addr,             32'h200);
    chk("c_ramwe_d",   {31'd0, ram_we},      32'd0);
    chk("c_fstall1",   {31'd0, fetch_stall}, 32'd1);
    chk("c_mstall1",   {31'd0, mem_stall},   32'd1);
    ram_ack   = 1'b1;
    ram_rdata = 32'h1234_5678;
    tick();
    ram_ack   = 1'b0;
    chk("c_mdone",   {31'd0, mem_done},    32'd1);
    chk("c_mrdata",  mem_rdata,            32'h1234_5678);
    chk("c_fstall2", {31'd0, fetch_stall}, 32'd1);
    chk("c_idle",    {31'd0, ram_req},     32'd0);
    mem_req = 1'b0;
    tick();
    chk("c_freq",     {31'd0, ram_req},     32'd1);
    chk("c_ramaddr_f", ram_addr,            32'h44);
    chk("c_fstall3",  {31'd0, fetch_stall}, 32'd1);
    ram_ack   = 1'b1;
    ram_rdata = 32'h8C09_0000;
    tick();
    ram_ack   = 1'b0;
    chk("c_fvalid", {31'd0, fetch_valid}, 32'd1);
    chk("c_fdata",  fetch_data,           32'h8C09_0000);
    fetch_req = 1'b0;
    tick();

    // ---------------- no double issue: req still high in pulse cycle ----------------
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0300;
    tick();
    ram_ack   = 1'b1;
    ram_rdata = 32'h0000_0011;
    tick();
    ram_ack   = 1'b0;
    chk("d_done",  {31'd0, mem_done}, 32'd1);
    chk("d_rdata", mem_rdata,         32'h11);
    tick();
    chk("d_noissue", {31'd0, ram_req},  32'd0);
    chk("d_done0",   {31'd0, mem_done}, 32'd0);
    mem_req = 1'b0;
    tick();
    chk("d_noissue2", {31'd0, ram_req}, 32'd0);

    // ---------------- starvation guard, limit 4 ----------------
    for (int i = 0; i < 4; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_0080;
      mem_req    = 1'b1;
      mem_we     = 1'b0;
      mem_addr   = 32'h0000_0400 + 32'(i * 4);
      tick();
      chk("st_dgrant", ram_addr, 32'h0000_0400 + 32'(i * 4));
      chk("st_cnt", {28'd0, dut.starve_cnt_q}, 32'(i + 1));
      ram_ack   = 1'b1;
      ram_rdata = 32'(i);
      tick();
      ram_ack   = 1'b0;
      chk("st_done", {31'd0, mem_done}, 32'd1);
      mem_req   = 1'b0;
      fetch_req = 1'b0;
      tick();
    end
    fetch_req = 1'b1;
    mem_req   = 1'b1;
    mem_addr  = 32'h0000_0410;
    tick();
    chk("st_fgrant",  ram_addr,                 32'h80);
    chk("st_cnt0",    {28'd0, dut.starve_cnt_q}, 32'd0);
    chk("st_mstall",  {31'd0, mem_stall},       32'd1);
    ram_ack   = 1'b1;
    ram_rdata = 32'hAAAA_5555;
    tick();
    ram_ack   = 1'b0;
    chk("st_fvalid", {31'd0, fetch_valid}, 32'd1);
    chk("st_fdata",  fetch_data,           32'hAAAA_5555);
    fetch_req = 1'b0;
    tick();
    chk("st_dgrant2", ram_addr,            32'h410);
    chk("st_ramreq2", {31'd0, ram_req},    32'd1);
    ram_ack   = 1'b1;
    ram_rdata = 32'h0BAD_F00D;
    tick();
    ram_ack   = 1'b0;
    chk("st_mrdata", mem_rdata, 32'h0BAD_F00D);
    mem_req = 1'b0;
    tick();

    // ---------------- reset during DATA_WAIT, stray ack afterwards ----------------
    mem_req  = 1'b1;
    mem_we   = 1'b1;
    mem_addr = 32'h0000_0500;
    mem_wdata = 32'hCAFE_0001;
    tick();
    chk("r_ramreq", {31'd0, ram_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("r_ramreq0",  {31'd0, ram_req}, 32'd0);
    chk("r_ramwe0",   {31'd0, ram_we},  32'd0);
    chk("r_ramaddr0", ram_addr,         32'd0);
    chk("r_wdata0",   ram_wdata,        32'd0);
    chk("r_mrdata0",  mem_rdata,        32'd0);
    chk("r_fdata0",   fetch_data,       32'd0);
    mem_req = 1'b0;
    mem_we  = 1'b0;
    tick();
    reset_n = 1'b1;
    ram_ack   = 1'b1;
    ram_rdata = 32'h7777_7777;
    tick();
    ram_ack = 1'b0;
    chk("r_nodone",  {31'd0, mem_done},    32'd0);
    chk("r_novalid", {31'd0, fetch_valid}, 32'd0);
    chk("r_mrdata",  mem_rdata,            32'd0);
    tick();
    chk("r_nodone2", {31'd0, mem_done}, 32'd0);
    chk("r_idle",    {31'd0, ram_req},  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
